// File: rtl/div_clk_monitor_if.sv
// Divided-clock checker bus: stimulus toward the monitor, measurements and status back.
`timescale 1ns/1ps
interface div_clk_monitor_if #(
  parameter int W = 8
);
  logic         div_clk;
  logic         enable;
  logic [W-1:0] expected_div;
  logic [W-1:0] meas_period;
  logic [W-1:0] meas_high;
  logic         meas_valid;
  logic         lock;
  logic         err_period;
  logic         err_duty;
  logic         err_timeout;
  logic [7:0]   err_count;

  modport master (
    output div_clk, enable, expected_div,
    input  meas_period, meas_high, meas_valid, lock,
    input  err_period, err_duty, err_timeout, err_count
  );

  modport slave (
    input  div_clk, enable, expected_div,
    output meas_period, meas_high, meas_valid, lock,
    output err_period, err_duty, err_timeout, err_count
  );
endinterface

// File: rtl/div_clk_monitor.sv
// Samples a divided clock in the clk_in domain, measures period/high time and checks them.
// Optional saturating error counter enabled by defining DIV_MON_ERRCNT_EN.
`timescale 1ns/1ps
module div_clk_monitor #(
  parameter int W          = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  div_clk_monitor_if.slave bus
);
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [3:0]   LOCK_N  = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, WAIT, MEAS, LOCKED} state_e;

  state_e       state_q, state_d;
  logic         s1_q, s2_q, s3_q;
  logic [W-1:0] per_cnt_q, per_cnt_d;
  logic [W-1:0] high_cnt_q, high_cnt_d;
  logic [W-1:0] meas_period_q, meas_period_d;
  logic [W-1:0] meas_high_q, meas_high_d;
  logic [3:0]   good_cnt_q, good_cnt_d, good_inc;
  logic         meas_valid_q, meas_valid_d;
  logic         lock_q, lock_d;
  logic         err_period_q, err_period_d;
  logic         err_duty_q, err_duty_d;
  logic         err_timeout_q, err_timeout_d;
  logic         rise, hi, per_bad, duty_bad;
  logic [W-1:0] half_lo, half_hi;

  assign rise     = s2_q & ~s3_q;
  assign hi       = s2_q;
  assign half_lo  = bus.expected_div >> 1;
  assign half_hi  = half_lo + {{(W-1){1'b0}}, bus.expected_div[0]};
  assign per_bad  = (per_cnt_q != bus.expected_div);
  assign duty_bad = (high_cnt_q != half_lo) && (high_cnt_q != half_hi);
  assign good_inc = (good_cnt_q == LOCK_N) ? good_cnt_q : good_cnt_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    per_cnt_d     = per_cnt_q;
    high_cnt_d    = high_cnt_q;
    meas_period_d = meas_period_q;
    meas_high_d   = meas_high_q;
    good_cnt_d    = good_cnt_q;
    meas_valid_d  = 1'b0;
    lock_d        = lock_q;
    err_period_d  = 1'b0;
    err_duty_d    = 1'b0;
    err_timeout_d = err_timeout_q;

    if (state_q != IDLE) begin
      if (per_cnt_q != CNT_MAX) per_cnt_d = per_cnt_q + CNT_ONE;
      if (hi && (high_cnt_q != CNT_MAX)) high_cnt_d = high_cnt_q + CNT_ONE;
    end

    if (!bus.enable) begin
      state_d       = IDLE;
      per_cnt_d     = '0;
      high_cnt_d    = '0;
      good_cnt_d    = '0;
      lock_d        = 1'b0;
      err_timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          if (rise) begin
            per_cnt_d     = CNT_ONE;
            high_cnt_d    = CNT_ONE;
            err_timeout_d = 1'b0;
            state_d       = MEAS;
          end
        end
        MEAS, LOCKED: begin
          // A rise wins over a simultaneous saturation: the 2^W-1 period is judged, not timed out.
          if (rise) begin
            per_cnt_d     = CNT_ONE;
            high_cnt_d    = CNT_ONE;
            meas_period_d = per_cnt_q;
            meas_high_d   = high_cnt_q;
            meas_valid_d  = 1'b1;
            err_period_d  = per_bad;
            err_duty_d    = duty_bad;
            if (per_bad || duty_bad) begin
              good_cnt_d = '0;
              lock_d     = 1'b0;
              state_d    = MEAS;
            end else begin
              good_cnt_d = good_inc;
              if (good_inc == LOCK_N) begin
                lock_d  = 1'b1;
                state_d = LOCKED;
              end
            end
          end else if (per_cnt_q == CNT_MAX) begin
            err_timeout_d = 1'b1;
            lock_d        = 1'b0;
            good_cnt_d    = '0;
            state_d       = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef DIV_MON_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;
  logic       err_event;

  assign err_event = err_period_d | err_duty_d | (err_timeout_d & ~err_timeout_q);

  always_comb begin
    err_count_d = err_count_q;
    if (!bus.enable) err_count_d = '0;
    else if (err_event && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = '0;
`endif

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      per_cnt_q     <= '0;
      high_cnt_q    <= '0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      good_cnt_q    <= '0;
      meas_valid_q  <= 1'b0;
      lock_q        <= 1'b0;
      err_period_q  <= 1'b0;
      err_duty_q    <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef DIV_MON_ERRCNT_EN
      err_count_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      s1_q          <= bus.div_clk;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      per_cnt_q     <= per_cnt_d;
      high_cnt_q    <= high_cnt_d;
      meas_period_q <= meas_period_d;
      meas_high_q   <= meas_high_d;
      good_cnt_q    <= good_cnt_d;
      meas_valid_q  <= meas_valid_d;
      lock_q        <= lock_d;
      err_period_q  <= err_period_d;
      err_duty_q    <= err_duty_d;
      err_timeout_q <= err_timeout_d;
`ifdef DIV_MON_ERRCNT_EN
      err_count_q   <= err_count_d;
`endif
    end
  end

  assign bus.meas_period = meas_period_q;
  assign bus.meas_high   = meas_high_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.lock        = lock_q;
  assign bus.err_period  = err_period_q;
  assign bus.err_duty    = err_duty_q;
  assign bus.err_timeout = err_timeout_q;
endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
Checks a divided clock produced elsewhere in the design (for example a 50%-duty divide-by-N generator) by sampling it in the clk_in domain.
- Measures period and high time of the divided clock in clk_in cycles.
- Compares the measurements against an expected divide ratio.
- Reports lock, per-period errors and stuck-clock timeout.
- Acts as the checking end of the clock-divider interface; used in bring-up and as a run-time health monitor.

Parameters:
W, 8, width of the expected ratio, the counters and the measurement outputs.
LOCK_COUNT, 4, consecutive good periods required to assert lock (1..15).

Ports:
clk_in  input  1  sampling clock; the same clock that feeds the divider under test.
reset_n  input  1  asynchronous, active-low reset.
div_clk  input  1  divided clock under test; treated as asynchronous.
enable  input  1  monitor enable; 0 holds the monitor idle.
expected_div  input  W  expected period in clk_in cycles (valid range 2..2^W-2); sampled on every detected rising edge.
meas_period  output  W  last measured period.
meas_high  output  W  last measured high time.
meas_valid  output  1  one-cycle pulse when meas_* update.
lock  output  1  ratio and duty confirmed.
err_period  output  1  one-cycle pulse when a period mismatches.
err_duty  output  1  one-cycle pulse when the duty cycle is out of range.
err_timeout  output  1  level: no rising edge for 2^W-1 cycles.
err_count  output  8  saturating error count (see Optional Feature).

Behaviour:
- Reset (async, reset_n=0): all outputs 0, all counters 0, synchronizer flops 0, FSM in IDLE. Asserting reset mid-measurement aborts immediately; there is no partial update.
- Input path: 2-flop synchronizer s1→s2, then history flop s3.
  - rise = s2 & ~s3.
  - hi = s2.
  - Rise latency from a div_clk edge is 2–3 clk_in cycles.
- Counters (W bits, saturating at 2^W-1):
  - per_cnt increments every cycle.
  - high_cnt increments every cycle with hi=1.
  - On rise, both counters reload: per_cnt←1, high_cnt←1.
- FSM states:
  - IDLE: counters held at 0. Go to WAIT when enable=1.
  - WAIT: discard data until the first rise. On that rise, reload counters and go to MEAS. No meas_valid is produced here.
  - MEAS: count good periods; go to LOCKED when good_cnt reaches LOCK_COUNT.
  - LOCKED: stay while periods are good.
  - Leaving MEAS or LOCKED: enable=0 goes to IDLE the next cycle and clears lock.
- On each rise in MEAS or LOCKED (cycle R):
  - meas_period←per_cnt and meas_high←high_cnt at R+1.
  - meas_valid pulses at R+1.
- Period check: per_cnt ≠ expected_div → err_period pulse at R+1.
- Duty check: high_cnt must equal floor(E/2) or ceil(E/2), where E=expected_div. Otherwise err_duty pulses at R+1.
- Good period: no error. good_cnt increments, saturating at LOCK_COUNT.
- Any error:
  - good_cnt←0.
  - If in LOCKED, go to MEAS and drop lock at R+1.
  - err_period and err_duty may pulse together.
- Timeout:
  - When per_cnt saturates at 2^W-1 in MEAS or LOCKED: err_timeout←1, lock←0, good_cnt←0, FSM→WAIT.
  - err_timeout stays high until the next rise, or until enable=0 or reset.
- A rise in the same cycle enable falls is ignored.
- A change in expected_div takes effect at the next rise.

Optional Feature:
- Macro: DIV_MON_ERRCNT_EN.
- Defined: err_count increments by 1 on each cycle in which any of err_period, err_duty or a rising err_timeout occurs.
  - Saturates at 255.
  - Cleared by reset or by enable=0.
- Not defined: err_count is tied to 8'd0 and no counter logic is generated. The port list is identical in both builds.

Test Plan:
- W=8, LOCK_COUNT=4, expected_div=3, div_clk = 50%-duty clk_in/3 built from both clk_in edges → every meas_period=3, meas_high ∈ {1,2}, no error pulses, lock rises 1 cycle after the 4th evaluated rise.
- Same setup with expected_div=4 → err_period pulses once per period, meas_period=3, lock stays 0, err_count increments per error (macro defined) or reads 0 (macro undefined).
- expected_div=6, div_clk high 1 cycle / low 5 cycles → meas_period=6, meas_high=1, err_duty every period, err_period never.
- Locked at expected_div=3, then div_clk held low → err_timeout=1 and lock=0 once per_cnt reaches 255; restart div_clk → err_timeout clears at the first rise and lock returns after 4 more good periods.
- Locked, then reset_n pulled low between clk_in edges → all outputs 0 immediately; after release with enable=1, the first meas_valid appears only after two rises.
- Locked, enable=0 for 1 cycle → lock=0 and the FSM is in IDLE the next cycle; on re-enable, the first rise is not evaluated.
